// File: rtl/uart_rx.sv
// ============================================================================
// Module   : uart_rx
// Purpose  : 8N1 UART receiver with a per-frame mid-bit counter and selectable rate.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_rx #(
    parameter int FREQ       = 50_000_000,
    parameter int BAUD_2400  = 2400,
    parameter int BAUD_4800  = 4800,
    parameter int BAUD_9600  = 9600,
    parameter int BAUD_19200 = 19200
) (
    input  logic       clk,
    input  logic       arst_n,
    input  logic [1:0] baud_rate,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err
);

    localparam logic [15:0] c_BIT_2400  = 16'(FREQ / BAUD_2400);
    localparam logic [15:0] c_BIT_4800  = 16'(FREQ / BAUD_4800);
    localparam logic [15:0] c_BIT_9600  = 16'(FREQ / BAUD_9600);
    localparam logic [15:0] c_BIT_19200 = 16'(FREQ / BAUD_19200);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        rx_meta_q, rx_s_q, rx_prev_q;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] bit_cnt_q, bit_cnt_d;
    logic [15:0] half_cnt_q, half_cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic        frame_err_q, frame_err_d;

    logic [15:0] w_sel_bit_cnt;
    logic        w_fall;
    logic        w_half_done;
    logic        w_bit_done;

    always_comb begin
        case (baud_rate)
            2'b00:   w_sel_bit_cnt = c_BIT_2400;
            2'b01:   w_sel_bit_cnt = c_BIT_4800;
            2'b10:   w_sel_bit_cnt = c_BIT_9600;
            default: w_sel_bit_cnt = c_BIT_19200;
        endcase
    end

    // Edge-only detection keeps a line stuck low from re-triggering frames.
    assign w_fall      = rx_prev_q & ~rx_s_q;
    assign w_half_done = (cnt_q == half_cnt_q - 16'd1);
    assign w_bit_done  = (cnt_q == bit_cnt_q - 16'd1);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 16'd1;
        bit_cnt_d   = bit_cnt_q;
        half_cnt_d  = half_cnt_q;
        bit_idx_d   = bit_idx_q;
        shreg_d     = shreg_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (w_fall) begin
                    bit_cnt_d  = w_sel_bit_cnt;
                    half_cnt_d = w_sel_bit_cnt >> 1;
                    state_d    = S_START;
                end
            end
            S_START: begin
                if (w_half_done) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rx_s_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (w_bit_done) begin
                    cnt_d     = '0;
                    shreg_d   = {rx_s_q, shreg_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                // Leaving at mid-stop lets a start edge at the end of the stop bit be caught.
                if (w_bit_done) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    if (rx_s_q) begin
                        rx_data_d  = shreg_q;
                        rx_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q     <= S_IDLE;
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            rx_prev_q   <= 1'b1;
            cnt_q       <= '0;
            bit_cnt_q   <= '0;
            half_cnt_q  <= '0;
            bit_idx_q   <= '0;
            shreg_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rx_meta_q   <= rx;
            rx_s_q      <= rx_meta_q;
            rx_prev_q   <= rx_s_q;
            cnt_q       <= cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            half_cnt_q  <= half_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shreg_q     <= shreg_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
// Module   : tb_uart_rx
// Purpose  : Self-checking bench for uart_rx; clock scaled down so frames stay short.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_rx;

    localparam int TB_FREQ = 1_000_000;

    logic       clk;
    logic       arst_n;
    logic [1:0] baud_rate;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;

    int         n_checks;
    int         n_fail;
    int         n_valid;
    int         n_ferr;
    int         n_both;
    logic [7:0] got_q[$];

    uart_rx #(
        .FREQ      (TB_FREQ),
        .BAUD_2400 (2400),
        .BAUD_4800 (4800),
        .BAUD_9600 (9600),
        .BAUD_19200(19200)
    ) u_dut (
        .clk      (clk),
        .arst_n   (arst_n),
        .baud_rate(baud_rate),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .frame_err(frame_err)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid) begin
            n_valid++;
            got_q.push_back(rx_data);
        end
        if (frame_err) n_ferr++;
        if (rx_valid && frame_err) n_both++;
    end

    function automatic int baud_of(input logic [1:0] r);
        case (r)
            2'b00:   return 2400;
            2'b01:   return 4800;
            2'b10:   return 9600;
            default: return 19200;
        endcase
    endfunction

    // Serial bit length in ns: truncated cycles-per-bit times the 20 ns clock.
    function automatic longint bit_ns(input logic [1:0] r);
        return longint'(TB_FREQ / baud_of(r)) * 20;
    endfunction

    function automatic logic [7:0] got_at(input int i);
        if (i < got_q.size()) return got_q[i];
        return 8'hxx;
    endfunction

    task automatic clear_mon();
        @(posedge clk);
        n_valid = 0;
        n_ferr  = 0;
        n_both  = 0;
        got_q.delete();
        @(negedge clk);
    endtask

    // Rate is changed at random after the start bit; the frame must ignore it.
    task automatic send_frame(input logic [7:0] b, input logic [1:0] r, input logic stop);
        longint t;
        t = bit_ns(r);
        baud_rate = r;
        rx = 1'b0;
        #(t);
        baud_rate = 2'($urandom);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            #(t);
        end
        rx = stop;
        #(t);
        rx = 1'b1;
    endtask

    task automatic idle_bits(input int n, input logic [1:0] r);
        rx = 1'b1;
        #(bit_ns(r) * n);
    endtask

    task automatic test_reset();
        arst_n = 1'b0;
        rx = 1'b1;
        baud_rate = 2'b10;
        repeat (5) @(negedge clk);
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", rx_valid); end
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_ferr got=%b exp=0", frame_err); end
        n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got=%h exp=00", rx_data); end
        arst_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_single_byte();
        clear_mon();
        send_frame(8'h55, 2'b10, 1'b1);
        idle_bits(1, 2'b10);
        n_checks++; if (n_valid !== 1) begin n_fail++; $display("FAIL single_count got=%0d exp=1", n_valid); end
        n_checks++; if (got_at(0) !== 8'h55) begin n_fail++; $display("FAIL single_data got=%h exp=55", got_at(0)); end
        n_checks++; if (n_ferr !== 0) begin n_fail++; $display("FAIL single_ferr got=%0d exp=0", n_ferr); end
    endtask

    task automatic test_rate_change();
        clear_mon();
        send_frame(8'hA3, 2'b11, 1'b1);
        idle_bits(1, 2'b11);
        send_frame(8'h3C, 2'b00, 1'b1);
        idle_bits(1, 2'b00);
        n_checks++; if (n_valid !== 2) begin n_fail++; $display("FAIL rates_count got=%0d exp=2", n_valid); end
        n_checks++; if (got_at(0) !== 8'hA3) begin n_fail++; $display("FAIL rates_first got=%h exp=a3", got_at(0)); end
        n_checks++; if (got_at(1) !== 8'h3C) begin n_fail++; $display("FAIL rates_second got=%h exp=3c", got_at(1)); end
        n_checks++; if (n_ferr !== 0) begin n_fail++; $display("FAIL rates_ferr got=%0d exp=0", n_ferr); end
    endtask

    // A short low pulse must be rejected and the receiver re-armed for the next frame.
    task automatic test_glitch();
        clear_mon();
        baud_rate = 2'b10;
        rx = 1'b0;
        #400;
        rx = 1'b1;
        #(bit_ns(2'b10));
        n_checks++; if (n_valid !== 0) begin n_fail++; $display("FAIL glitch_valid got=%0d exp=0", n_valid); end
        n_checks++; if (n_ferr !== 0) begin n_fail++; $display("FAIL glitch_ferr got=%0d exp=0", n_ferr); end
        send_frame(8'h5A, 2'b10, 1'b1);
        idle_bits(1, 2'b10);
        n_checks++; if (n_valid !== 1 || rx_data !== 8'h5A) begin
            n_fail++; $display("FAIL glitch_rearm got=%0d/%h exp=1/5a", n_valid, rx_data);
        end
    endtask

    task automatic test_frame_err();
        clear_mon();
        send_frame(8'h12, 2'b10, 1'b1);
        idle_bits(1, 2'b10);
        clear_mon();
        send_frame(8'h81, 2'b10, 1'b0);
        idle_bits(1, 2'b10);
        n_checks++; if (n_ferr !== 1) begin n_fail++; $display("FAIL ferr_count got=%0d exp=1", n_ferr); end
        n_checks++; if (n_valid !== 0) begin n_fail++; $display("FAIL ferr_valid got=%0d exp=0", n_valid); end
        n_checks++; if (rx_data !== 8'h12) begin n_fail++; $display("FAIL ferr_data got=%h exp=12", rx_data); end
    endtask

    task automatic test_async_reset();
        logic [7:0] b;
        longint     t;
        b = 8'hF0;
        t = bit_ns(2'b10);
        clear_mon();
        baud_rate = 2'b10;
        rx = 1'b0;
        #(t);
        for (int i = 0; i < 3; i++) begin
            rx = b[i];
            #(t);
        end
        rx = b[3];
        #(t / 2);
        @(negedge clk);
        arst_n = 1'b0;
        #1;
        n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL arst_data got=%h exp=00", rx_data); end
        n_checks++; if (rx_valid !== 1'b0 || frame_err !== 1'b0) begin
            n_fail++; $display("FAIL arst_pulses got=%b%b exp=00", rx_valid, frame_err);
        end
        rx = 1'b1;
        #99;
        arst_n = 1'b1;
        idle_bits(12, 2'b10);
        n_checks++; if (n_valid !== 0 || n_ferr !== 0) begin
            n_fail++; $display("FAIL arst_abort got=%0d/%0d exp=0/0", n_valid, n_ferr);
        end
        send_frame(8'h0F, 2'b10, 1'b1);
        idle_bits(1, 2'b10);
        n_checks++; if (n_valid !== 1 || rx_data !== 8'h0F) begin
            n_fail++; $display("FAIL arst_next got=%0d/%h exp=1/0f", n_valid, rx_data);
        end
    endtask

    task automatic test_back_to_back();
        clear_mon();
        send_frame(8'h00, 2'b10, 1'b1);
        send_frame(8'hFF, 2'b10, 1'b1);
        idle_bits(1, 2'b10);
        n_checks++; if (n_valid !== 2) begin n_fail++; $display("FAIL b2b_count got=%0d exp=2", n_valid); end
        n_checks++; if (got_at(0) !== 8'h00 || got_at(1) !== 8'hFF) begin
            n_fail++; $display("FAIL b2b_data got=%h,%h exp=00,ff", got_at(0), got_at(1));
        end
        n_checks++; if (n_ferr !== 0) begin n_fail++; $display("FAIL b2b_ferr got=%0d exp=0", n_ferr); end
    endtask

    // Reference: good frames queue their byte, bad stop bits count as frame errors.
    task automatic test_random();
        logic [7:0] exp_q[$];
        logic [7:0] last_good;
        int         exp_ferr;
        logic [7:0] b;
        logic [1:0] r;
        logic       stop;
        int         gap;
        exp_ferr  = 0;
        last_good = rx_data;
        clear_mon();
        for (int k = 0; k < 12; k++) begin
            b    = 8'($urandom);
            r    = 2'($urandom);
            stop = ($urandom_range(0, 4) != 0);
            gap  = stop ? int'($urandom_range(0, 1)) : 1;
            send_frame(b, r, stop);
            if (stop) begin
                exp_q.push_back(b);
                last_good = b;
            end else begin
                exp_ferr++;
            end
            if (gap != 0) idle_bits(gap, r);
        end
        idle_bits(1, 2'b00);
        n_checks++; if (n_valid !== exp_q.size()) begin
            n_fail++; $display("FAIL rand_count got=%0d exp=%0d", n_valid, exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++; if (got_at(i) !== exp_q[i]) begin
                n_fail++; $display("FAIL rand_data[%0d] got=%h exp=%h", i, got_at(i), exp_q[i]);
            end
        end
        n_checks++; if (n_ferr !== exp_ferr) begin n_fail++; $display("FAIL rand_ferr got=%0d exp=%0d", n_ferr, exp_ferr); end
        n_checks++; if (rx_data !== last_good) begin n_fail++; $display("FAIL rand_last got=%h exp=%h", rx_data, last_good); end
        n_checks++; if (n_both !== 0) begin n_fail++; $display("FAIL rand_both got=%0d exp=0", n_both); end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        n_valid   = 0;
        n_ferr    = 0;
        n_both    = 0;
        arst_n    = 1'b0;
        rx        = 1'b1;
        baud_rate = 2'b10;
        @(negedge clk);
        test_reset();
        test_single_byte();
        test_rate_change();
        test_glitch();
        test_frame_err();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
